pipelined_simple_dual_port_ram: RTL and testbench

Single-clock simple dual-port RAM with one write port and one read port. Adds sectioned (byte-style) write masking, a configurable read pipeline with a valid flag, and a selectable read/write collision policy. Used as the storage core for synchronous FIFOs, line buffers and register-file-style tables where a clean valid-qualified read stream is needed.

---
 rtl/pipelined_simple_dual_port_ram_pkg.sv | 20 ++
 rtl/pipelined_simple_dual_port_ram_valid_data_pipeline.sv | 41 ++++
 rtl/pipelined_simple_dual_port_ram.sv | 111 +++++++++++
 tb/tb_pipelined_simple_dual_port_ram.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipelined_simple_dual_port_ram_pkg.sv
// Shared constants and helpers for the pipelined simple dual-port RAM.
// Covers the collision-policy encodings, the legal read-latency bound and parameter derivations.
package pipelined_simple_dual_port_ram_pkg;

  localparam int unsigned POLICY_READ_FIRST  = 0;
  localparam int unsigned POLICY_WRITE_FIRST = 1;
  localparam int unsigned MAX_READ_LATENCY   = 4;

  // Address width for a given depth; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = (n < 2) ? 1 : $clog2(n);
    return r;
  endfunction

  function automatic int unsigned sections(input int unsigned width, input int unsigned section_width);
    return width / section_width;
  endfunction

endpackage

// File: rtl/pipelined_simple_dual_port_ram_valid_data_pipeline.sv
// Chain of valid-qualified data registers; data stages load only when their incoming valid is set.
module valid_data_pipeline #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  if (STAGES == 0) begin : g_bypass
    assign o_valid = i_valid;
    assign o_data  = i_data;
  end else begin : g_stages
    logic             r_valid [STAGES];
    logic [WIDTH-1:0] r_data  [STAGES];

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < STAGES; i++) begin
          r_valid[i] <= 1'b0;
          r_data[i]  <= '0;
        end
      end else begin
        r_valid[0] <= i_valid;
        if (i_valid) r_data[0] <= i_data;
        for (int i = 1; i < STAGES; i++) begin
          r_valid[i] <= r_valid[i-1];
          if (r_valid[i-1]) r_data[i] <= r_data[i-1];
        end
      end
    end

    assign o_valid = r_valid[STAGES-1];
    assign o_data  = r_data[STAGES-1];
  end

endmodule

// File: rtl/pipelined_simple_dual_port_ram.sv
// Single-clock simple dual-port RAM with sectioned write mask, selectable collision policy
// and a valid-qualified read pipeline of READ_LATENCY register stages.
module pipelined_simple_dual_port_ram
  import pipelined_simple_dual_port_ram_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned ADDRESS_WIDTH = clog2_min1(DEPTH),
  parameter int unsigned SECTION_WIDTH = 8,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned WRITE_FIRST   = POLICY_READ_FIRST
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        write_enable,
  input  logic [ADDRESS_WIDTH-1:0]                    write_address,
  input  logic [sections(WIDTH, SECTION_WIDTH)-1:0]   write_mask,
  input  logic [WIDTH-1:0]                            write_data,
  input  logic                                        read_enable,
  input  logic [ADDRESS_WIDTH-1:0]                    read_address,
  output logic                                        read_valid,
  output logic [WIDTH-1:0]                            read_data
);

  localparam int unsigned SECTIONS   = sections(WIDTH, SECTION_WIDTH);
  localparam bit          FULL_DEPTH = (DEPTH == (32'd1 << ADDRESS_WIDTH));

  if ((WIDTH % SECTION_WIDTH) != 0) begin : g_bad_section
    $fatal(1, "WIDTH must be a multiple of SECTION_WIDTH");
  end
  if ((READ_LATENCY < 1) || (READ_LATENCY > MAX_READ_LATENCY)) begin : g_bad_latency
    $fatal(1, "READ_LATENCY must be in 1..4");
  end

  logic             w_wr_in_range;
  logic             w_rd_in_range;
  logic             w_collision;
  logic [WIDTH-1:0] w_old_word;
  logic [WIDTH-1:0] w_merged_word;
  logic [WIDTH-1:0] w_read_word;
  logic             r_rd_valid;
  logic [WIDTH-1:0] r_rd_data;
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Addresses past the last word exist only when DEPTH is not a power of two.
  if (FULL_DEPTH) begin : g_full_range
    assign w_wr_in_range = 1'b1;
    assign w_rd_in_range = 1'b1;
  end else begin : g_partial_range
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
    assign w_wr_in_range = (write_address <= LAST_ADDR);
    assign w_rd_in_range = (read_address <= LAST_ADDR);
  end

  always_ff @(posedge clock) begin : p_write
    if (!reset && write_enable && w_wr_in_range) begin
      for (int s = 0; s < SECTIONS; s++) begin
        if (write_mask[s]) begin
          r_mem[write_address][s*SECTION_WIDTH +: SECTION_WIDTH] <=
            write_data[s*SECTION_WIDTH +: SECTION_WIDTH];
        end
      end
    end
  end

  // Word presented to the first read register, including the write-first merge.
  always_comb begin : p_read_word
    w_old_word    = '0;
    w_merged_word = '0;
    w_read_word   = '0;
    w_collision   = 1'b0;
    if (w_rd_in_range) w_old_word = r_mem[read_address];
    w_merged_word = w_old_word;
    for (int s = 0; s < SECTIONS; s++) begin
      if (write_mask[s]) begin
        w_merged_word[s*SECTION_WIDTH +: SECTION_WIDTH] = write_data[s*SECTION_WIDTH +: SECTION_WIDTH];
      end
    end
    w_collision = write_enable && w_wr_in_range && (write_address == read_address);
    w_read_word = w_old_word;
    if ((WRITE_FIRST == POLICY_WRITE_FIRST) && w_collision) w_read_word = w_merged_word;
  end

  always_ff @(posedge clock) begin : p_read_stage
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= read_enable;
      if (read_enable) r_rd_data <= w_read_word;
    end
  end

  if (READ_LATENCY == 1) begin : g_no_pipe
    assign read_valid = r_rd_valid;
    assign read_data  = r_rd_data;
  end else begin : g_pipe
    valid_data_pipeline #(
      .WIDTH  (WIDTH),
      .STAGES (READ_LATENCY - 1)
    ) u_pipe (
      .clock   (clock),
      .reset   (reset),
      .i_valid (r_rd_valid),
      .i_data  (r_rd_data),
      .o_valid (read_valid),
      .o_data  (read_data)
    );
  end

endmodule

// File: tb/tb_pipelined_simple_dual_port_ram.sv
// Scoreboard bench: three RAM instances (read-first L3, write-first L4, read-first L1) share stimulus.
module tb_pipelined_simple_dual_port_ram;

  localparam int RL0 = 3;
  localparam int RL1 = 4;
  localparam int RL2 = 1;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  wa = '0;
  logic [3:0]  wm = '0;
  logic [31:0] wd = '0;
  logic        re = 1'b0;
  logic [3:0]  ra = '0;

  logic        v0, v1, v2;
  logic [31:0] d0, d1, d2;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic drain_req = 1'b0;
  logic drain_done = 1'b0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t e;
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;
  logic [31:0] last2 = '0;
  logic [31:0] golden [12];

  pipelined_simple_dual_port_ram #(.WIDTH(32), .DEPTH(12), .SECTION_WIDTH(8),
    .READ_LATENCY(RL0), .WRITE_FIRST(0)) dut_rf3 (
    .clock(clock), .reset(reset), .write_enable(we), .write_address(wa), .write_mask(wm),
    .write_data(wd), .read_enable(re), .read_address(ra), .read_valid(v0), .read_data(d0));

  pipelined_simple_dual_port_ram #(.WIDTH(32), .DEPTH(12), .SECTION_WIDTH(8),
    .READ_LATENCY(RL1), .WRITE_FIRST(1)) dut_wf4 (
    .clock(clock), .reset(reset), .write_enable(we), .write_address(wa), .write_mask(wm),
    .write_data(wd), .read_enable(re), .read_address(ra), .read_valid(v1), .read_data(d1));

  pipelined_simple_dual_port_ram #(.WIDTH(32), .DEPTH(12), .SECTION_WIDTH(8),
    .READ_LATENCY(RL2), .WRITE_FIRST(0)) dut_rf1 (
    .clock(clock), .reset(reset), .write_enable(we), .write_address(wa), .write_mask(wm),
    .write_data(wd), .read_enable(re), .read_address(ra), .read_valid(v2), .read_data(d2));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Per-instance check: zero during reset, hold value when idle, exact data and cycle when valid.
`define CHK(Q, V, D, LAST, NM) \
  if (reset) begin \
    n_cmp++; \
    if (V !== 1'b0 || D !== 32'h0) begin \
      n_err++; $display("FAIL %s reset_out: valid=%b data=%h, required valid=0 data=0", NM, V, D); \
    end \
    LAST = 32'h0; \
  end else if (V === 1'b1) begin \
    n_cmp++; \
    if (Q.size() == 0) begin \
      n_err++; $display("FAIL %s spurious_valid: cycle=%0d data=%h, required no valid", NM, cyc, D); \
    end else begin \
      e = Q.pop_front(); LAST = e.data; \
      if (D !== e.data || cyc != e.due) begin \
        n_err++; $display("FAIL %s read: data=%h cycle=%0d, required data=%h cycle=%0d", NM, D, cyc, e.data, e.due); \
      end \
    end \
  end else begin \
    n_cmp++; \
    if (V !== 1'b0 || D !== LAST) begin \
      n_err++; $display("FAIL %s hold: valid=%b data=%h, required valid=0 data=%h", NM, V, D, LAST); \
    end \
    if (Q.size() != 0 && Q[0].due <= cyc) begin \
      n_cmp++; n_err++; \
      $display("FAIL %s missing_valid: cycle=%0d, required data=%h at cycle %0d", NM, cyc, Q[0].data, Q[0].due); \
      void'(Q.pop_front()); \
    end \
  end

  always @(negedge clock) begin
    `CHK(q0, v0, d0, last0, "dut_rf3")
    `CHK(q1, v1, d1, last1, "dut_wf4")
    `CHK(q2, v2, d2, last2, "dut_rf1")
    if (drain_req && !drain_done) begin
      n_cmp++;
      if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
        n_err++;
        $display("FAIL drain: pending=%0d/%0d/%0d, required 0/0/0", q0.size(), q1.size(), q2.size());
      end
      drain_done = 1'b1;
    end
  end

  task automatic drive(input logic we_i, input logic [3:0] wa_i, input logic [3:0] wm_i,
                       input logic [31:0] wd_i, input logic re_i, input logic [3:0] ra_i,
                       input logic [31:0] e_rf, input logic [31:0] e_wf);
    exp_t x;
    @(negedge clock);
    #1;
    we = we_i; wa = wa_i; wm = wm_i; wd = wd_i; re = re_i; ra = ra_i;
    if (re_i && !reset) begin
      x.data = e_rf; x.due = cyc + RL0; q0.push_back(x);
      x.data = e_wf; x.due = cyc + RL1; q1.push_back(x);
      x.data = e_rf; x.due = cyc + RL2; q2.push_back(x);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] m, input logic [31:0] d);
    drive(1'b1, a, m, d, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp_d);
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a, exp_d, exp_d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic set_reset(input logic val);
    @(negedge clock);
    #1;
    reset = val;
    we = 1'b0; re = 1'b0;
    if (val) begin
      q0.delete(); q1.delete(); q2.delete();
    end
  endtask

  initial begin
    idle(3);
    set_reset(1'b0);

    for (int i = 0; i < 12; i++) wr(4'(i), 4'hF, 32'hA000_0000 | 32'(i));
    wr(4'd3, 4'b0001, 32'h0000_00A5);
    rd(4'd3, 32'hA000_00A5);
    wr(4'd4, 4'hF, 32'h1122_3344);
    wr(4'd4, 4'b0101, 32'hAABB_CCDD);
    rd(4'd4, 32'h11BB_33DD);
    wr(4'd5, 4'hF, 32'h0000_000F);
    drive(1'b1, 4'd5, 4'hF, 32'h0000_00F0, 1'b1, 4'd5, 32'h0000_000F, 32'h0000_00F0);
    drive(1'b1, 4'd6, 4'b1000, 32'hFFFF_FFFF, 1'b1, 4'd6, 32'hA000_0006, 32'hFF00_0006);
    rd(4'd6, 32'hFF00_0006);
    wr(4'd7, 4'b0000, 32'h1234_5678);
    rd(4'd7, 32'hA000_0007);
    wr(4'd13, 4'hF, 32'hFFFF_FFFF);
    rd(4'd13, 32'h0);
    rd(4'd12, 32'h0);
    drive(1'b1, 4'd13, 4'hF, 32'hFFFF_FFFF, 1'b1, 4'd13, 32'h0, 32'h0);

    for (int i = 0; i < 12; i++) golden[i] = 32'hA000_0000 | 32'(i);
    golden[3] = 32'hA000_00A5;
    golden[4] = 32'h11BB_33DD;
    golden[5] = 32'h0000_00F0;
    golden[6] = 32'hFF00_0006;
    for (int i = 0; i < 12; i++) rd(4'(i), golden[i]);
    idle(6);

    rd(4'd0, golden[0]);
    rd(4'd1, golden[1]);
    rd(4'd2, golden[2]);
    set_reset(1'b1);
    drive(1'b1, 4'd1, 4'hF, 32'hFFFF_FFFF, 1'b1, 4'd1, 32'h0, 32'h0);
    idle(1);
    set_reset(1'b0);
    rd(4'd1, 32'hA000_0001);
    rd(4'd4, 32'h11BB_33DD);
    idle(8);

    drain_req = 1'b1;
    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
